// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for counter snapshot logic.
//   COUNT_WIDTH_DEFAULT / BYTE_WIDTH_DEFAULT : default counter and beat widths
//   NBYTES / IDX_W                           : beats per snapshot and index width
//   state_e                                  : serializer FSM states
//   idx_bits()                               : index width for an arbitrary beat count
package counter_pkg;

  localparam int unsigned COUNT_WIDTH_DEFAULT = 128;
  localparam int unsigned BYTE_WIDTH_DEFAULT  = 8;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NBYTES = COUNT_WIDTH_DEFAULT / BYTE_WIDTH_DEFAULT;
  localparam int unsigned IDX_W  = idx_bits(NBYTES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/counter_snapshot_serializer_sat_counter8.sv
// sat_counter8: 8-bit incrementer that sticks at 255 instead of wrapping.
//   clk     : clock
//   reset   : asynchronous, active-high; clears the count
//   inc_i   : increment request for this cycle
//   count_o : current count
module sat_counter8
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  output logic [7:0] count_o
);

  logic [7:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_snapshot_serializer.sv
// counter_snapshot_serializer: freezes count_in on a capture request and
// streams it LSB-first as BYTE_WIDTH beats over a valid/ready interface.
// Captures arriving mid-stream are dropped and counted.
//   clk, reset    : clock; asynchronous active-high reset
//   count_in      : counter value, sampled only on an accepted capture
//   capture       : snapshot request (one request per high cycle)
//   clear_overrun : synchronous clear of overrun (a same-cycle drop wins)
//   out_data      : current beat (registered)
//   out_valid     : out_data valid; busy mirrors it
//   out_ready     : sink accepts the beat
//   out_last      : current beat is the most significant byte
//   overrun       : sticky, at least one capture dropped
//   drop_cnt      : dropped-capture count, saturating at 255
module counter_snapshot_serializer
  import counter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
  parameter int unsigned BYTE_WIDTH  = BYTE_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   capture,
  input  logic                   clear_overrun,
  output logic [BYTE_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overrun,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned N_BEATS  = COUNT_WIDTH / BYTE_WIDTH;
  localparam int unsigned IDX_BITS = idx_bits(N_BEATS);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_BEATS - 1);

  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] shadow_q;
  logic [IDX_BITS-1:0]    idx_q;
  logic [IDX_BITS-1:0]    idx_d;
  logic [BYTE_WIDTH-1:0]  data_q;
  logic                   last_q;
  logic                   overrun_q;

  logic xfer;
  logic last_xfer;
  logic load;
  logic drop;

  always_comb begin
    xfer      = (state_q == SEND) && out_ready;
    last_xfer = xfer && (idx_q == LAST_IDX);
    // A capture is taken from IDLE, or on the last-beat transfer so that
    // back-to-back snapshots stream without an idle bubble.
    load      = capture && ((state_q == IDLE) || last_xfer);
    drop      = capture && (state_q == SEND) && !last_xfer;
    idx_d     = idx_q + 1'b1;
  end

  // out_data/out_last are registered copies of the shadow byte mux, so
  // they are updated together with idx and simply hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load) begin
        state_q  <= SEND;
        shadow_q <= count_in;
        idx_q    <= '0;
        data_q   <= count_in[BYTE_WIDTH-1:0];
        last_q   <= (LAST_IDX == '0);
      end else if (xfer) begin
        if (idx_q == LAST_IDX) begin
          state_q <= IDLE;
          idx_q   <= '0;
          data_q  <= '0;
          last_q  <= 1'b0;
        end else begin
          idx_q  <= idx_d;
          data_q <= shadow_q[idx_d*BYTE_WIDTH +: BYTE_WIDTH];
          last_q <= (idx_d == LAST_IDX);
        end
      end

      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  sat_counter8 u_drop_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (drop),
    .count_o (drop_cnt)
  );

  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_counter_snapshot_serializer.sv
// Scoreboard bench for counter_snapshot_serializer: the stimulus process
// pushes expected {last, byte} beats; a negedge monitor pops and compares
// on every accepted beat and checks data stability during stalls.
module tb_counter_snapshot_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] count_in;
  logic         capture;
  logic         clear_overrun;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         overrun;
  logic [7:0]   drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  counter_snapshot_serializer #(.COUNT_WIDTH(128), .BYTE_WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .count_in      (count_in),
    .capture       (capture),
    .clear_overrun (clear_overrun),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .overrun       (overrun),
    .drop_cnt      (drop_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_snapshot(input logic [127:0] v);
    for (int i = 0; i < 16; i++) sb.push_back({(i == 15), v[i*8 +: 8]});
  endtask

  // One-cycle capture pulse; the snapshot is expected to stream in full.
  task automatic cap(input logic [127:0] v);
    count_in = v;
    capture  = 1'b1;
    push_snapshot(v);
    tick();
    capture = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
    chk("drain", sb.size(), 0);
  endtask

  // Monitor
  logic [8:0] held;
  bit         stalled = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else if (out_valid) begin
      chk("busy_eq_valid", busy, 1);
      if (stalled) chk("stall_hold", {out_last, out_data}, held);
      if (out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", {out_last, out_data}, $time);
        end else begin
          chk("beat", {out_last, out_data}, sb.pop_front());
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = {out_last, out_data};
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [127:0] pat;
  bit [1:0]     rdy_pat [4] = '{1, 0, 0, 1};

  initial begin
    reset = 1'b1; count_in = '0; capture = 1'b0; clear_overrun = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Idle with no capture
    repeat (5) tick();
    chk("idle_valid", out_valid, 0);
    chk("idle_data", out_data, 0);
    chk("idle_last", out_last, 0);
    chk("idle_drop", drop_cnt, 0);
    chk("idle_overrun", overrun, 0);

    // Single snapshot, sink always ready
    cap(128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_data", out_data, 8'h00);
    chk("t1_first_last", out_last, 0);
    repeat (15) tick();
    chk("t1_last_data", out_data, 8'h0F);
    chk("t1_last_flag", out_last, 1);
    tick();
    chk("t1_back_idle", out_valid, 0);
    chk("t1_all_beats", sb.size(), 0);

    // Same snapshot with sink toggling 1,0,0,1
    cap(128'h0F0E0D0C0B0A09080706050403020100);
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      out_ready = rdy_pat[i % 4][0];
      tick();
    end
    out_ready = 1'b1;
    chk("t2_drain", sb.size(), 0);
    tick();
    chk("t2_idle", out_valid, 0);

    // Snapshot is immune to count_in changing mid-stream
    cap('1);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      count_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    chk("t3_drain", sb.size(), 0);
    chk("t3_no_drop", drop_cnt, 0);

    // Capture held high: back-to-back streams, 15 drops per stream
    for (int k = 0; k < 18; k++) begin
      pat = {4{32'hA5C3_0000 | 32'(k)}};
      count_in = pat;
      capture  = 1'b1;
      push_snapshot(pat);
      if (k == 0) tick();
      else repeat (16) tick();
      if (k == 2)  chk("t4_drop_30", drop_cnt, 30);
      if (k == 17) chk("t4_drop_255", drop_cnt, 255);
      if (k == 1)  chk("t4_no_bubble", out_valid, 1);
    end
    repeat (5) tick();
    capture = 1'b0;
    chk("t4_drop_sat", drop_cnt, 255);
    chk("t4_overrun", overrun, 1);
    wait_drain(40);

    // Reset mid-stream (after beat 5), with a drop pending beforehand
    cap(128'h1F1E1D1C1B1A19181716151413121110);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    repeat (5) tick();
    chk("t5_pre_overrun", overrun, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_last", out_last, 0);
    chk("t5_rst_overrun", overrun, 0);
    chk("t5_rst_drop", drop_cnt, 0);
    chk("t5_rst_remaining", sb.size(), 10);
    sb.delete();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("t5_no_resume", out_valid, 0);

    // clear_overrun colliding with a drop: set wins
    cap(128'h2F2E2D2C2B2A29282726252423222120);
    tick();
    capture = 1'b1;
    clear_overrun = 1'b1;
    tick();
    capture = 1'b0;
    clear_overrun = 1'b0;
    chk("t6_collide_overrun", overrun, 1);
    chk("t6_collide_drop", drop_cnt, 1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("t6_cleared", overrun, 0);
    chk("t6_drop_kept", drop_cnt, 1);
    wait_drain(40);
    tick();
    chk("t6_idle", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_snapshot_serializer.md
# counter_snapshot_serializer

Downstream consumer of the 128-bit free-running counter. On a capture request it freezes the current count into a shadow register and streams it out LSB-first as bytes over a valid/ready interface. The byte stream feeds a narrow debug/readout link. Captures that arrive while a snapshot is still streaming are dropped and accounted for.

## Interface
- COUNT_WIDTH, 128, width of sampled counter; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, width of output beat
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  reset, asynchronous, active-high
- count_in  input  COUNT_WIDTH  counter value to sample
- capture  input  1  snapshot request, sampled each rising edge; level, one request per high cycle
- clear_overrun  input  1  synchronous clear of overrun flag
- out_data  output  BYTE_WIDTH  current beat, registered
- out_valid  output  1  out_data is valid
- out_ready  input  1  sink accepts beat
- out_last  output  1  current beat is the final (most significant) byte
- busy  output  1  snapshot in progress (equals out_valid)
- overrun  output  1  sticky: at least one capture dropped
- drop_cnt  output  8  dropped-capture count, saturates at 255

## Operation
- NBYTES = COUNT_WIDTH/BYTE_WIDTH (16 by default); byte index idx is ceil(log2(NBYTES)) bits wide.
- FSM states: IDLE, SEND.
- IDLE: out_valid=0. capture=1 -> shadow<=count_in, idx<=0, go to SEND.
- SEND: out_valid=1, out_data=shadow[idx*BYTE_WIDTH +: BYTE_WIDTH], out_last=(idx==NBYTES-1).
- Transfer = out_valid & out_ready. On transfer with idx<NBYTES-1: idx<=idx+1.
- On transfer of last beat: capture=1 in the same cycle -> reload shadow from count_in, idx<=0, stay in SEND (no bubble); otherwise go to IDLE.
- capture=1 in SEND in any cycle other than a last-beat transfer: request dropped, overrun<=1, drop_cnt<=drop_cnt+1 unless it is already 255.
- clear_overrun=1: overrun<=0. If a drop occurs in the same cycle, set wins (overrun=1). clear_overrun does not affect drop_cnt.
- out_data, out_last and shadow are held stable while out_valid=1 and out_ready=0.
- count_in is sampled only on an accepted capture edge; later changes do not alter the snapshot being streamed.

## Timing
- Reset (async assert, any state): state=IDLE, shadow=0, idx=0, out_valid=0, out_data=0, out_last=0, busy=0, overrun=0, drop_cnt=0. Outputs go to these values immediately on reset assertion, without waiting for a clock edge.
- A reset asserted during SEND aborts the snapshot; the partial stream is not resumed.
- Capture accepted at edge N -> out_valid=1 with byte 0 from edge N.
- With out_ready held high: one beat per cycle; the last beat is presented 15 cycles after byte 0 (16 beats in total).
- With back-to-back captures timed on last-beat transfers: continuous 16-beat streams with zero idle cycles.
- A drop is reflected in overrun/drop_cnt one edge after the dropped capture.

## Structure
- Shared package counter_pkg:
  - COUNT_WIDTH and BYTE_WIDTH defaults
  - NBYTES and idx width
  - state enum {IDLE, SEND}
- Sub-module sat_counter8: 8-bit saturating incrementer with async reset, used for drop_cnt.
- FSM, shadow register and byte mux live in the top module.

## Test plan
- Reset then idle, out_ready=1, no capture -> out_valid stays 0; drop_cnt=0; overrun=0.
- count_in=128'h0F0E0D0C0B0A09080706050403020100, one capture pulse, out_ready=1 -> beats 00,01,…,0F on consecutive cycles; out_last only on 0F; then IDLE.
- Same capture, out_ready toggling 1,0,0,1,… -> every byte delivered exactly once in order; data stable while stalled.
- capture held high continuously with out_ready=1 -> back-to-back 16-beat streams, each reloaded at its last beat; 15 drops per stream; drop_cnt saturates at 255 and does not wrap; overrun=1.
- capture with count_in=128'hFFFF…FF, then count_in changes mid-stream -> all 16 beats are FF.
- Reset asserted mid-stream (after beat 5), then clear_overrun pulsed while a drop occurs -> immediate return to IDLE with all outputs 0; in the clear/drop collision cycle overrun remains 1.
